// File: rtl/pipe_share_arbiter_pkg.sv
// Shared types and helpers for the pipe_share arbiter slice.
package pipe_share_pkg;

  localparam int unsigned MAX_NUM_REQ = 8;
  localparam int unsigned IDX_W       = $clog2(MAX_NUM_REQ);

  // One entry of the tag delay line: which requester owns the op in that slot.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Round-robin pick: first eligible index at or above ptr, wrapping at num_req.
  function automatic logic [MAX_NUM_REQ-1:0] rr_onehot(
    input logic [MAX_NUM_REQ-1:0] eligible,
    input logic [IDX_W-1:0]       ptr,
    input int unsigned            num_req
  );
    logic [MAX_NUM_REQ-1:0] sel;
    logic                   found;
    int unsigned            pos;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_NUM_REQ; k++) begin
      pos = (32'(ptr) + k) % num_req;
      if ((k < num_req) && !found && eligible[pos[IDX_W-1:0]]) begin
        sel[pos[IDX_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_share_arbiter_if.sv
// Requester, datapath and credit signals of the shared-pipe arbiter.
// slave = arbiter side, master = environment (requesters + datapath).
interface pipe_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16
);

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0][WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          o_dp_valid;
  logic [WIDTH-1:0]              o_dp_data;
  logic [WIDTH-1:0]              i_dp_result;
  logic [NUM_REQ-1:0]            o_rsp_valid;
  logic [WIDTH-1:0]              o_rsp_data;
  logic [NUM_REQ-1:0]            i_credit_return;
  logic                          o_credit_err;

  modport slave (
    input  i_req_valid, i_req_data, i_dp_result, i_credit_return,
    output o_req_ready, o_dp_valid, o_dp_data, o_rsp_valid, o_rsp_data, o_credit_err
  );

  modport master (
    output i_req_valid, i_req_data, i_dp_result, i_credit_return,
    input  o_req_ready, o_dp_valid, o_dp_data, o_rsp_valid, o_rsp_data, o_credit_err
  );

endinterface

// File: rtl/pipe_share_arbiter_tag_line.sv
// Tag delay line matching the datapath latency; reset drops every in-flight tag.
module pipe_share_tag_line
  import pipe_share_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [LATENCY];

  // Shift tags one stage per cycle; only the valid bits need clearing on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_stage[s].valid <= 1'b0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int s = 1; s < LATENCY; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_tag = r_stage[LATENCY-1];

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined datapath, with
// per-requester credits and tag-based response routing.
module pipe_share_arbiter
  import pipe_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned CREDITS = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  pipe_share_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W      = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

  logic [IDX_W-1:0]       r_ptr;
  logic [CNT_W-1:0]       r_credit [NUM_REQ];
  logic                   r_credit_err;
  logic                   r_dp_valid;
  logic [WIDTH-1:0]       r_dp_data;
  logic [IDX_W-1:0]       r_dp_idx;
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [WIDTH-1:0]       r_rsp_data;

  logic [NUM_REQ-1:0]     w_eligible;
  logic [MAX_NUM_REQ-1:0] w_elig_ext;
  logic [MAX_NUM_REQ-1:0] w_sel;
  logic                   w_unused_sel;
  logic [NUM_REQ-1:0]     w_grant;
  logic                   w_grant_any;
  logic [IDX_W-1:0]       w_grant_idx;
  logic [WIDTH-1:0]       w_grant_data;
  logic [IDX_W-1:0]       w_ptr_next;
  tag_t                   w_tag_in;
  tag_t                   w_tag_out;

  // Eligibility uses registered credits; nothing is granted while in reset.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = bus.i_req_valid[i] && (r_credit[i] != '0) && !i_rst;
    end
    w_elig_ext                = '0;
    w_elig_ext[NUM_REQ-1:0]   = w_eligible;
    w_sel                     = rr_onehot(w_elig_ext, r_ptr, NUM_REQ);
    w_grant                   = w_sel[NUM_REQ-1:0];
    w_grant_any               = |w_grant;
  end

  assign w_unused_sel = ^w_sel;

  // Encode the one-hot grant and mux the winning operand.
  always_comb begin
    w_grant_idx  = '0;
    w_grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_grant_idx  = IDX_W'(i);
        w_grant_data = bus.i_req_data[i];
      end
    end
    w_ptr_next = (32'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + 1'b1;
  end

  // Credit counters: grant and return together cancel; overflowing return flags an error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_credit[i] <= CREDIT_MAX;
      end
      r_credit_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({w_grant[i], bus.i_credit_return[i]})
          2'b01: begin
            if (r_credit[i] == CREDIT_MAX) begin
              r_credit_err <= 1'b1;
            end else begin
              r_credit[i] <= r_credit[i] + 1'b1;
            end
          end
          2'b10:   r_credit[i] <= r_credit[i] - 1'b1;
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end
  end

  // Issue register and round-robin pointer; operand holds when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_dp_valid <= 1'b0;
      r_dp_data  <= '0;
      r_dp_idx   <= '0;
    end else begin
      r_dp_valid <= w_grant_any;
      if (w_grant_any) begin
        r_ptr     <= w_ptr_next;
        r_dp_data <= w_grant_data;
        r_dp_idx  <= w_grant_idx;
      end
    end
  end

  // The issue register already accounts for the first cycle, so the tag line
  // adds exactly LATENCY more to line up with i_dp_result.
  assign w_tag_in.valid = r_dp_valid;
  assign w_tag_in.idx   = r_dp_idx;

  pipe_share_tag_line #(
    .LATENCY (LATENCY)
  ) u_tag_line (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Route the datapath result to the originator of the exiting tag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= w_tag_out.valid && (w_tag_out.idx == IDX_W'(i));
      end
      if (w_tag_out.valid) begin
        r_rsp_data <= bus.i_dp_result;
      end
    end
  end

  assign bus.o_req_ready  = w_grant;
  assign bus.o_dp_valid   = r_dp_valid;
  assign bus.o_dp_data    = r_dp_data;
  assign bus.o_rsp_valid  = r_rsp_valid;
  assign bus.o_rsp_data   = r_rsp_data;
  assign bus.o_credit_err = r_credit_err;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter with a delay-line datapath model.
module tb_pipe_share_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned LATENCY = 4;
  localparam int unsigned CREDITS = 4;
  localparam logic [WIDTH-1:0] DP_ADD = 16'h9999;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  pipe_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  pipe_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .CREDITS (CREDITS)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Datapath model: LATENCY registered stages, result = operand + DP_ADD.
  logic [WIDTH-1:0] dp_pipe [LATENCY];
  always @(posedge i_clk) begin
    dp_pipe[0] <= bus.o_dp_data;
    for (int s = 1; s < LATENCY; s++) dp_pipe[s] <= dp_pipe[s-1];
  end
  assign bus.i_dp_result = dp_pipe[LATENCY-1] + DP_ADD;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  logic [NUM_REQ-1:0] man_ret;
  bit                 auto_ret;

  task automatic step();
    @(posedge i_clk);
    #1;
    bus.i_credit_return = man_ret | (auto_ret ? bus.o_rsp_valid : '0);
  endtask

  task automatic do_reset();
    i_rst             = 1'b1;
    bus.i_req_valid   = '0;
    man_ret           = '0;
    auto_ret          = 1'b0;
    step();
    step();
    i_rst = 1'b0;
  endtask

  // Response monitor: counts responses; in tracking mode checks routing and order.
  int               rsp_cnt   = 0;
  int               route_err = 0;
  bit               track     = 1'b0;
  logic [WIDTH-1:0] exp_q [NUM_REQ][$];

  always @(negedge i_clk) begin
    if (!i_rst && (bus.o_rsp_valid != '0)) begin
      rsp_cnt++;
      if (track) begin
        if ($countones(bus.o_rsp_valid) != 1) route_err++;
        else begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.o_rsp_valid[i]) begin
              if (exp_q[i].size() == 0) route_err++;
              else if (exp_q[i].pop_front() + DP_ADD != bus.o_rsp_data) route_err++;
            end
          end
        end
      end
    end
  end

  initial begin
    int cnt [NUM_REQ];
    int order_err;
    int grants;
    int ready_err;
    int grants_tot;
    int left;
    int m_ptr;
    int m_cred [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] exp_g;
    logic [NUM_REQ-1:0] g;

    bus.i_req_valid     = '0;
    bus.i_req_data      = '0;
    bus.i_credit_return = '0;
    man_ret             = '0;
    auto_ret            = 1'b0;

    // Reset state, with all requesters valid during reset.
    i_rst           = 1'b1;
    bus.i_req_valid = '1;
    step();
    step();
    #1;
    check_eq("rst_ready", bus.o_req_ready, 4'b0000);
    check_eq("rst_dp_valid", bus.o_dp_valid, 1'b0);
    check_eq("rst_dp_data", bus.o_dp_data, 16'h0000);
    check_eq("rst_rsp_valid", bus.o_rsp_valid, 4'b0000);
    check_eq("rst_rsp_data", bus.o_rsp_data, 16'h0000);
    check_eq("rst_credit_err", bus.o_credit_err, 1'b0);
    bus.i_req_valid = '0;
    i_rst           = 1'b0;
    step();

    // Single requester: 0x1234 in, 0x1234+0x9999 = 0xABCD back on requester 2.
    bus.i_req_data[2] = 16'h1234;
    bus.i_req_valid   = 4'b0100;
    #1 check_eq("single_grant", bus.o_req_ready, 4'b0100);
    step();
    bus.i_req_valid = '0;
    #1;
    check_eq("single_dp_valid", bus.o_dp_valid, 1'b1);
    check_eq("single_dp_data", bus.o_dp_data, 16'h1234);
    step();
    #1;
    check_eq("single_dp_idle", bus.o_dp_valid, 1'b0);
    check_eq("single_dp_hold", bus.o_dp_data, 16'h1234);
    repeat (LATENCY - 1) step();
    #1 check_eq("single_rsp_early", bus.o_rsp_valid, 4'b0000);
    step();
    #1;
    check_eq("single_rsp_valid", bus.o_rsp_valid, 4'b0100);
    check_eq("single_rsp_data", bus.o_rsp_data, 16'hABCD);
    step();
    #1 check_eq("single_rsp_done", bus.o_rsp_valid, 4'b0000);

    // Fairness: everyone valid, credits returned on each response.
    do_reset();
    auto_ret = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) bus.i_req_data[i] = WIDTH'(16'h0100 * i);
    bus.i_req_valid = '1;
    order_err = 0;
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      g = bus.o_req_ready;
      if (g != (4'b0001 << (c % NUM_REQ))) order_err++;
      for (int i = 0; i < NUM_REQ; i++) if (g[i]) cnt[i]++;
      step();
    end
    check_eq("fair_order_err", order_err, 0);
    for (int i = 0; i < NUM_REQ; i++) check_eq($sformatf("fair_cnt%0d", i), cnt[i], 25);
    bus.i_req_valid = '0;
    repeat (12) step();

    // Credit exhaustion on requester 0.
    do_reset();
    bus.i_req_valid = 4'b0001;
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.o_req_ready[0]) grants++;
      step();
    end
    check_eq("exh_grants", grants, 4);
    #1 check_eq("exh_blocked", bus.o_req_ready, 4'b0000);
    man_ret             = 4'b0001;
    bus.i_credit_return = 4'b0001;
    #1 check_eq("exh_ret_cycle", bus.o_req_ready, 4'b0000);
    man_ret = '0;
    step();
    #1 check_eq("exh_regrant", bus.o_req_ready, 4'b0001);
    step();
    #1 check_eq("exh_reblocked", bus.o_req_ready, 4'b0000);
    bus.i_req_valid = '0;
    repeat (10) step();

    // Grant and return together on requester 1 at credit 2.
    do_reset();
    bus.i_req_valid = 4'b0010;
    step();
    step();
    man_ret             = 4'b0010;
    bus.i_credit_return = 4'b0010;
    #1 check_eq("sim_grant", bus.o_req_ready, 4'b0010);
    man_ret = '0;
    step();
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.o_req_ready[1]) grants++;
      step();
    end
    check_eq("sim_credit_kept", grants, 2);
    check_eq("sim_no_err", bus.o_credit_err, 1'b0);
    bus.i_req_valid = '0;
    repeat (10) step();

    // Return at full credit: ignored, sticky error until reset.
    do_reset();
    #1 check_eq("err_clear_start", bus.o_credit_err, 1'b0);
    man_ret             = 4'b0001;
    bus.i_credit_return = 4'b0001;
    man_ret             = '0;
    step();
    #1 check_eq("err_set", bus.o_credit_err, 1'b1);
    bus.i_req_valid = 4'b0001;
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.o_req_ready[0]) grants++;
      step();
    end
    check_eq("err_credit_cap", grants, 4);
    check_eq("err_sticky", bus.o_credit_err, 1'b1);
    do_reset();
    #1 check_eq("err_cleared", bus.o_credit_err, 1'b0);

    // Reset with three operations in flight.
    bus.i_req_valid = 4'b0111;
    step();
    step();
    step();
    bus.i_req_valid = '0;
    i_rst           = 1'b1;
    rsp_cnt         = 0;
    step();
    i_rst = 1'b0;
    repeat (12) step();
    check_eq("rstf_no_rsp", rsp_cnt, 0);
    bus.i_req_valid = 4'b1010;
    #1 check_eq("rstf_lowest", bus.o_req_ready, 4'b0010);
    bus.i_req_valid = 4'b0001;
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.o_req_ready[0]) grants++;
      step();
    end
    check_eq("rstf_credit0", grants, 4);
    bus.i_req_valid = '0;
    repeat (10) step();

    // Sparse random traffic against a reference arbiter/credit model.
    do_reset();
    auto_ret   = 1'b1;
    track      = 1'b1;
    rsp_cnt    = 0;
    route_err  = 0;
    ready_err  = 0;
    grants_tot = 0;
    m_ptr      = 0;
    for (int i = 0; i < NUM_REQ; i++) m_cred[i] = CREDITS;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.i_req_valid[i] = ($urandom_range(99) < 30);
        bus.i_req_data[i]  = WIDTH'($urandom);
      end
      #1;
      for (int i = 0; i < NUM_REQ; i++) elig[i] = bus.i_req_valid[i] && (m_cred[i] > 0);
      exp_g = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if ((exp_g == '0) && elig[idx]) exp_g[idx] = 1'b1;
      end
      if (bus.o_req_ready !== exp_g) ready_err++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_g[i]) begin
          exp_q[i].push_back(bus.i_req_data[i]);
          m_ptr = (i + 1) % NUM_REQ;
          grants_tot++;
        end
        m_cred[i] = m_cred[i] + int'(bus.i_credit_return[i]) - int'(exp_g[i]);
      end
      step();
    end
    bus.i_req_valid = '0;
    repeat (20) step();
    left = 0;
    for (int i = 0; i < NUM_REQ; i++) left += exp_q[i].size();
    check_eq("sparse_ready_err", ready_err, 0);
    check_eq("sparse_route_err", route_err, 0);
    check_eq("sparse_rsp_count", rsp_cnt, grants_tot);
    check_eq("sparse_leftover", left, 0);
    check_eq("sparse_busy", grants_tot > 500, 1'b1);
    check_eq("sparse_no_err", bus.o_credit_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
